// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat round controller.
//
// Contents:
//   NATURAL_MIN_DEF, PLAYER_DRAW_MAX_DEF, BANKER_STAND_MIN_DEF  default rule thresholds
//   ST_*            state encodings as plain 4-bit constants
//   bac_state_t     FSM state enum built on the ST_* encodings
//   bac_result_t    registered hand outcome (P_WIN, D_WIN, TIE)
//   banker_tableau  full punto-banco banker draw table; used only when
//                   BACCARAT_BANKER_TABLE_EN is defined
package baccarat_pkg;

  localparam int NATURAL_MIN_DEF      = 8;
  localparam int PLAYER_DRAW_MAX_DEF  = 5;
  localparam int BANKER_STAND_MIN_DEF = 7;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_P1     = 4'd1;
  localparam logic [3:0] ST_D1     = 4'd2;
  localparam logic [3:0] ST_P2     = 4'd3;
  localparam logic [3:0] ST_D2     = 4'd4;
  localparam logic [3:0] ST_EV2    = 4'd5;
  localparam logic [3:0] ST_P3     = 4'd6;
  localparam logic [3:0] ST_EV3    = 4'd7;
  localparam logic [3:0] ST_D3     = 4'd8;
  localparam logic [3:0] ST_EVF    = 4'd9;
  localparam logic [3:0] ST_RESULT = 4'd10;

  typedef enum logic [3:0] {
    S_IDLE   = ST_IDLE,
    S_P1     = ST_P1,
    S_D1     = ST_D1,
    S_P2     = ST_P2,
    S_D2     = ST_D2,
    S_EV2    = ST_EV2,
    S_P3     = ST_P3,
    S_EV3    = ST_EV3,
    S_D3     = ST_D3,
    S_EVF    = ST_EVF,
    S_RESULT = ST_RESULT
  } bac_state_t;

  typedef enum logic [1:0] {
    P_WIN = 2'd0,
    D_WIN = 2'd1,
    TIE   = 2'd2
  } bac_result_t;

  // Banker draw decision after the player took a third card.
  // d = banker two-card score, c = value of the player's third card.
  function automatic logic banker_tableau(input logic [3:0] d, input logic [3:0] c);
    logic draw;
    draw = 1'b0;
    case (d)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (c != 4'd8);
      4'd4:             draw = (c >= 4'd2) && (c <= 4'd7);
      4'd5:             draw = (c >= 4'd4) && (c <= 4'd7);
      4'd6:             draw = (c >= 4'd6) && (c <= 4'd7);
      default:          draw = 1'b0;
    endcase
    return draw;
  endfunction

endpackage

// File: rtl/baccarat_tally.sv
// Three saturating win/loss/tie counters.
//
// Ports:
//   slow_clock   clock
//   clear        synchronous clear, active-high (wins over inc)
//   inc[2:0]     one-hot increment: [0] player, [1] dealer, [2] tie
//   player_wins, dealer_wins, ties   TALLY_W-bit counts, hold at all-ones
module baccarat_tally #(
  parameter int TALLY_W = 8
) (
  input  logic               slow_clock,
  input  logic               clear,
  input  logic [2:0]         inc,
  output logic [TALLY_W-1:0] player_wins,
  output logic [TALLY_W-1:0] dealer_wins,
  output logic [TALLY_W-1:0] ties
);

  localparam logic [TALLY_W-1:0] TALLY_MAX = '1;
  localparam logic [TALLY_W-1:0] TALLY_ONE = TALLY_W'(1);

  always_ff @(posedge slow_clock) begin
    if (clear) begin
      player_wins <= '0;
      dealer_wins <= '0;
      ties        <= '0;
    end else begin
      if (inc[0] && (player_wins != TALLY_MAX)) player_wins <= player_wins + TALLY_ONE;
      if (inc[1] && (dealer_wins != TALLY_MAX)) dealer_wins <= dealer_wins + TALLY_ONE;
      if (inc[2] && (ties        != TALLY_MAX)) ties        <= ties + TALLY_ONE;
    end
  end

endmodule

// File: rtl/baccarat_round_ctrl.sv
// Multi-round baccarat hand sequencer.
//
// Walks the card load strobes for one hand, applies the natural, player
// third-card and banker third-card rules, registers the winner, keeps
// saturating tallies and leaves RESULT on ack (AUTO_NEXT=0) or after
// HOLD_CYCLES cycles (AUTO_NEXT=1).
//
// Build option: define BACCARAT_BANKER_TABLE_EN for the full punto-banco
// banker tableau in EV3; otherwise the banker draws iff
// dscore < BANKER_STAND_MIN-1 and pcard3 is ignored.
//
// Handshake: start is a level sampled only in IDLE; ack is a level sampled
// only in RESULT (and only when AUTO_NEXT=0). Neither needs to be a pulse,
// but a start still high when RESULT returns to IDLE begins the next hand.
//
// Ports:
//   slow_clock, resetb          clock, synchronous active-low reset
//   start, ack                  hand start / result release
//   pscore, dscore, pcard3      scores and player third card from datapath
//   load_pcard1..3, load_dcard1..3   one-cycle card load strobes
//   player_win_light, dealer_win_light  outcome (both high = tie)
//   busy                        not IDLE
//   round_done                  one-cycle pulse on RESULT entry
//   player_wins, dealer_wins, ties      saturating tallies
//   dbg_state                   current FSM state encoding
module baccarat_round_ctrl
  import baccarat_pkg::*;
#(
  parameter int NATURAL_MIN      = NATURAL_MIN_DEF,
  parameter int PLAYER_DRAW_MAX  = PLAYER_DRAW_MAX_DEF,
  parameter int BANKER_STAND_MIN = BANKER_STAND_MIN_DEF,
  parameter int TALLY_W          = 8,
  parameter int AUTO_NEXT        = 0,
  parameter int HOLD_CYCLES      = 16
) (
  input  logic               slow_clock,
  input  logic               resetb,
  input  logic               start,
  input  logic               ack,
  input  logic [3:0]         pscore,
  input  logic [3:0]         dscore,
  input  logic [3:0]         pcard3,
  output logic               load_pcard1,
  output logic               load_pcard2,
  output logic               load_pcard3,
  output logic               load_dcard1,
  output logic               load_dcard2,
  output logic               load_dcard3,
  output logic               player_win_light,
  output logic               dealer_win_light,
  output logic               busy,
  output logic               round_done,
  output logic [TALLY_W-1:0] player_wins,
  output logic [TALLY_W-1:0] dealer_wins,
  output logic [TALLY_W-1:0] ties,
  output logic [3:0]         dbg_state
);

  localparam logic [3:0] NAT_MIN4    = 4'(NATURAL_MIN);
  localparam logic [3:0] P_DRAW_MAX4 = 4'(PLAYER_DRAW_MAX);
  localparam logic [3:0] B_STAND4    = 4'(BANKER_STAND_MIN);
  // Banker draws strictly below this on the simplified rule.
  localparam logic [3:0] B_DRAW_LT4  = 4'(BANKER_STAND_MIN - 1);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  bac_state_t        state_q, state_d;
  bac_result_t       win_q, win_d;
  logic [HOLD_W-1:0] hold_q;
  logic              enter_result;
  logic              banker_draw;
  logic [2:0]        tally_inc;

`ifdef BACCARAT_BANKER_TABLE_EN
  assign banker_draw = (dscore < B_STAND4) && banker_tableau(dscore, pcard3);
`else
  logic unused_pcard3;
  assign unused_pcard3 = ^{pcard3, B_STAND4};
  assign banker_draw   = (dscore < B_DRAW_LT4);
`endif

  // Outcome from whatever scores are on the inputs in the cycle that enters RESULT.
  always_comb begin
    win_d = D_WIN;
    if (pscore > dscore)       win_d = P_WIN;
    else if (pscore == dscore) win_d = TIE;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_P1;
      S_P1:   state_d = S_D1;
      S_D1:   state_d = S_P2;
      S_P2:   state_d = S_D2;
      S_D2:   state_d = S_EV2;
      S_EV2: begin
        if ((pscore >= NAT_MIN4) || (dscore >= NAT_MIN4)) state_d = S_RESULT;
        else if (pscore <= P_DRAW_MAX4)                   state_d = S_P3;
        else if (dscore < B_DRAW_LT4)                     state_d = S_D3;
        else                                              state_d = S_RESULT;
      end
      S_P3:   state_d = S_EV3;
      S_EV3:  state_d = banker_draw ? S_D3 : S_RESULT;
      S_D3:   state_d = S_EVF;
      S_EVF:  state_d = S_RESULT;
      S_RESULT: begin
        if (AUTO_NEXT != 0) begin
          if (hold_q == '0) state_d = S_IDLE;
        end else if (ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign enter_result = (state_d == S_RESULT) && (state_q != S_RESULT);

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      state_q    <= S_IDLE;
      win_q      <= P_WIN;
      round_done <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      round_done <= enter_result;
      if (enter_result) begin
        win_q  <= win_d;
        hold_q <= HOLD_LOAD;
      end else if ((state_q == S_RESULT) && (hold_q != '0)) begin
        hold_q <= hold_q - HOLD_ONE;
      end
    end
  end

  always_comb begin
    tally_inc = 3'b000;
    if (enter_result) begin
      case (win_d)
        P_WIN:   tally_inc = 3'b001;
        D_WIN:   tally_inc = 3'b010;
        default: tally_inc = 3'b100;
      endcase
    end
  end

  baccarat_tally #(.TALLY_W(TALLY_W)) u_tally (
    .slow_clock  (slow_clock),
    .clear       (!resetb),
    .inc         (tally_inc),
    .player_wins (player_wins),
    .dealer_wins (dealer_wins),
    .ties        (ties)
  );

  assign load_pcard1 = (state_q == S_P1);
  assign load_dcard1 = (state_q == S_D1);
  assign load_pcard2 = (state_q == S_P2);
  assign load_dcard2 = (state_q == S_D2);
  assign load_pcard3 = (state_q == S_P3);
  assign load_dcard3 = (state_q == S_D3);

  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

  assign player_win_light = (state_q == S_RESULT) && ((win_q == P_WIN) || (win_q == TIE));
  assign dealer_win_light = (state_q == S_RESULT) && ((win_q == D_WIN) || (win_q == TIE));

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Bench for baccarat_round_ctrl: a default-parameter instance driven by a
// small card-datapath model with random hands, and an AUTO_NEXT instance
// with a 2-bit tally for hold timing and saturation.
module tb_baccarat_round_ctrl;
  import baccarat_pkg::*;

  // ---------------- clock / reset ----------------
  logic slow_clock;
  logic resetb;

  initial begin
    slow_clock = 1'b0;
    forever #5 slow_clock = ~slow_clock;
  end

  // ---------------- main DUT ----------------
  logic       start, ack;
  logic [3:0] pscore, dscore, pcard3;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light, busy, round_done;
  logic [7:0] player_wins, dealer_wins, ties;
  logic [3:0] dbg_state;

  baccarat_round_ctrl u_dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
    .start            (start),
    .ack              (ack),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .busy             (busy),
    .round_done       (round_done),
    .player_wins      (player_wins),
    .dealer_wins      (dealer_wins),
    .ties             (ties),
    .dbg_state        (dbg_state)
  );

  // ---------------- AUTO_NEXT DUT ----------------
  logic       start_a, ack_a;
  logic [3:0] pscore_a, dscore_a, pcard3_a;
  logic       lp1_a, lp2_a, lp3_a, ld1_a, ld2_a, ld3_a;
  logic       pl_a, dl_a, busy_a, round_done_a;
  logic [1:0] player_wins_a, dealer_wins_a, ties_a;
  logic [3:0] dbg_state_a;

  baccarat_round_ctrl #(.TALLY_W(2), .AUTO_NEXT(1), .HOLD_CYCLES(4)) u_auto (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
    .start            (start_a),
    .ack              (ack_a),
    .pscore           (pscore_a),
    .dscore           (dscore_a),
    .pcard3           (pcard3_a),
    .load_pcard1      (lp1_a),
    .load_pcard2      (lp2_a),
    .load_pcard3      (lp3_a),
    .load_dcard1      (ld1_a),
    .load_dcard2      (ld2_a),
    .load_dcard3      (ld3_a),
    .player_win_light (pl_a),
    .dealer_win_light (dl_a),
    .busy             (busy_a),
    .round_done       (round_done_a),
    .player_wins      (player_wins_a),
    .dealer_wins      (dealer_wins_a),
    .ties             (ties_a),
    .dbg_state        (dbg_state_a)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  // Expected entry: {lights[1:0] = {player,dealer}, p_draw, d_draw, pw, dw, tw}
  localparam int EW = 28;
  logic [EW-1:0] exp_q[$];

  int m_pw, m_dw, m_tw;               // reference tallies
  int h_p2, h_d2, h_pc3, h_p3, h_d3;  // card values the datapath model will load

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Banker third-card decision, from the game rules.
  function automatic bit banker_rule(input int d, input int c);
`ifdef BACCARAT_BANKER_TABLE_EN
    if (d <= 2) return 1'b1;
    if (d == 3) return c != 8;
    if (d == 4) return c >= 2 && c <= 7;
    if (d == 5) return c >= 4 && c <= 7;
    if (d == 6) return c >= 6 && c <= 7;
    return 1'b0;
`else
    if (c > 99) return 1'b0;
    return d <= 5;
`endif
  endfunction

  // Whole-hand reference: scores after two cards, third cards, outcome and tallies.
  function automatic logic [EW-1:0] model_hand(input int p2, input int d2, input int pc3,
                                                input int p3, input int d3);
    int fp, fd;
    bit pd, dd;
    logic [1:0] lights;
    fp = p2; fd = d2; pd = 0; dd = 0;
    if (p2 >= 8 || d2 >= 8) begin
      // natural: nobody draws
    end else if (p2 <= 5) begin
      pd = 1; fp = p3;
      if (banker_rule(d2, pc3)) begin dd = 1; fd = d3; end
    end else if (d2 <= 5) begin
      dd = 1; fd = d3;
    end
    if (fp > fd) begin
      lights = 2'b10; if (m_pw < 255) m_pw++;
    end else if (fp == fd) begin
      lights = 2'b11; if (m_tw < 255) m_tw++;
    end else begin
      lights = 2'b01; if (m_dw < 255) m_dw++;
    end
    return {lights, pd, dd, 8'(m_pw), 8'(m_dw), 8'(m_tw)};
  endfunction

  // ---------------- card datapath model ----------------
  // A strobe seen during a cycle updates the score just after the next edge.
  initial begin
    bit c_p1, c_p2, c_p3, c_d1, c_d2, c_d3;
    pscore = 4'd0; dscore = 4'd0; pcard3 = 4'd0;
    forever begin
      @(negedge slow_clock);
      c_p1 = load_pcard1; c_p2 = load_pcard2; c_p3 = load_pcard3;
      c_d1 = load_dcard1; c_d2 = load_dcard2; c_d3 = load_dcard3;
      @(posedge slow_clock);
      #1;
      if (c_p1) pscore = 4'($urandom_range(0, 9));
      if (c_p2) pscore = 4'(h_p2);
      if (c_p3) begin pscore = 4'(h_p3); pcard3 = 4'(h_pc3); end
      if (c_d1) dscore = 4'($urandom_range(0, 9));
      if (c_d2) dscore = 4'(h_d2);
      if (c_d3) dscore = 4'(h_d3);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit seen_p3, seen_d3, prev_rd;
    logic [EW-1:0] e;
    seen_p3 = 0; seen_d3 = 0; prev_rd = 0;
    forever begin
      @(negedge slow_clock);
      if (resetb) begin
        if (load_pcard1) begin seen_p3 = 0; seen_d3 = 0; end
        if (load_pcard3) seen_p3 = 1;
        if (load_dcard3) seen_d3 = 1;
        check("strobe_onehot",
              32'($countones({load_pcard1, load_pcard2, load_pcard3,
                               load_dcard1, load_dcard2, load_dcard3}) <= 1), 32'd1);
        if (!busy) check("idle_lights_off", {30'd0, player_win_light, dealer_win_light}, 32'd0);
        if (round_done) begin
          check("round_done_single", 32'(prev_rd), 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_round_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("lights", {30'd0, player_win_light, dealer_win_light}, {30'd0, e[27:26]});
            check("player_drew", 32'(seen_p3), {31'd0, e[25]});
            check("banker_drew", 32'(seen_d3), {31'd0, e[24]});
            check("player_wins", {24'd0, player_wins}, {24'd0, e[23:16]});
            check("dealer_wins", {24'd0, dealer_wins}, {24'd0, e[15:8]});
            check("ties",        {24'd0, ties},        {24'd0, e[7:0]});
          end
        end
        prev_rd = round_done;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_round_done(output bit ok);
    int n;
    n = 0;
    do begin
      @(negedge slow_clock);
      n++;
    end while (!round_done && n < 60);
    ok = round_done;
    if (!ok) check("round_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_hand(input int p2, input int d2, input int pc3, input int p3,
                          input int d3, input bit ack_with_start);
    bit ok;
    h_p2 = p2; h_d2 = d2; h_pc3 = pc3; h_p3 = p3; h_d3 = d3;
    exp_q.push_back(model_hand(p2, d2, pc3, p3, d3));
    @(posedge slow_clock); #1 start = 1'b1;
    @(posedge slow_clock);
    // Occasionally leave start high into P1, where it must be ignored.
    if ($urandom_range(0, 1) == 1) begin
      @(posedge slow_clock);
    end
    #1 start = 1'b0;
    wait_round_done(ok);
    if (ok) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge slow_clock);
        check("hold_in_result", 32'(busy), 32'd1);
      end
      @(posedge slow_clock); #1;
      ack = 1'b1;
      if (ack_with_start) start = 1'b1;
      @(posedge slow_clock); #1;
      ack = 1'b0; start = 1'b0;
      @(negedge slow_clock);
      check("ack_to_idle", 32'(busy), 32'd0);
      @(negedge slow_clock);
      check("idle_stays", 32'(busy), 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int n, len;
    start = 0; ack = 0; resetb = 0;
    start_a = 0; ack_a = 1'b1; pscore_a = 4'd8; dscore_a = 4'd3; pcard3_a = 4'd0;
    m_pw = 0; m_dw = 0; m_tw = 0;
    h_p2 = 0; h_d2 = 0; h_pc3 = 0; h_p3 = 0; h_d3 = 0;
    repeat (3) @(posedge slow_clock);
    #1 resetb = 1'b1;
    @(negedge slow_clock);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_state", {28'd0, dbg_state}, {28'd0, ST_IDLE});
    check("reset_tallies", {8'd0, player_wins, dealer_wins, ties}, 32'd0);
    check("reset_round_done", 32'(round_done), 32'd0);

    // start is the only thing that leaves IDLE
    @(posedge slow_clock); #1 ack = 1'b1;
    @(posedge slow_clock); #1 ack = 1'b0;
    @(negedge slow_clock);
    check("ack_in_idle_ignored", 32'(busy), 32'd0);

    // Directed hands: natural, then the player-draw / banker-rule hand.
    run_hand(8, 3, 0, 0, 0, 1'b0);
    run_hand(4, 3, 8, 2, 2, 1'b0);
    run_hand(6, 6, 0, 0, 0, 1'b1);
    run_hand(7, 5, 0, 0, 2, 1'b0);

    // Random hands.
    for (int i = 0; i < 40; i++) begin
      run_hand($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
               $urandom_range(0, 9), $urandom_range(0, 9), ($urandom_range(0, 3) == 0));
    end

    // Reset in P3: abandon the hand, everything clears.
    h_p2 = 3; h_d2 = 0; h_pc3 = 5; h_p3 = 1; h_d3 = 1;
    @(posedge slow_clock); #1 start = 1'b1;
    @(posedge slow_clock); #1 start = 1'b0;
    n = 0;
    do begin
      @(negedge slow_clock);
      n++;
    end while (!load_pcard3 && n < 20);
    check("reach_p3", 32'(load_pcard3), 32'd1);
    resetb = 1'b0;
    @(posedge slow_clock); #1 resetb = 1'b1;
    @(negedge slow_clock);
    check("midhand_reset_state", {28'd0, dbg_state}, {28'd0, ST_IDLE});
    check("midhand_reset_outputs",
          {21'd0, busy, round_done, player_win_light, dealer_win_light,
           load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3}, 32'd0);
    check("midhand_reset_tallies", {8'd0, player_wins, dealer_wins, ties}, 32'd0);
    exp_q.delete();
    m_pw = 0; m_dw = 0; m_tw = 0;

    // First hand after reset: P1 strobe one cycle after start is taken.
    h_p2 = 5; h_d2 = 4; h_pc3 = 3; h_p3 = 9; h_d3 = 7;
    exp_q.push_back(model_hand(h_p2, h_d2, h_pc3, h_p3, h_d3));
    @(posedge slow_clock); #1 start = 1'b1;
    @(posedge slow_clock); #1 start = 1'b0;
    @(negedge slow_clock);
    check("p1_after_start", 32'(load_pcard1), 32'd1);
    wait_round_done(ok);
    @(posedge slow_clock); #1 ack = 1'b1;
    @(posedge slow_clock); #1 ack = 1'b0;
    @(negedge slow_clock);
    check("post_reset_idle", 32'(busy), 32'd0);
    check("post_reset_queue_empty", 32'(exp_q.size()), 32'd0);

    // AUTO_NEXT instance: natural player win every round, ack held high.
    for (int k = 1; k <= 4; k++) begin
      @(posedge slow_clock); #1 start_a = 1'b1;
      @(posedge slow_clock); #1 start_a = 1'b0;
      n = 0;
      do begin
        @(negedge slow_clock);
        n++;
      end while (!round_done_a && n < 30);
      check("auto_round_done", 32'(round_done_a), 32'd1);
      check("auto_lights", {30'd0, pl_a, dl_a}, 32'd2);
      check("auto_player_wins", {30'd0, player_wins_a}, (k < 3) ? 32'(k) : 32'd3);
      len = 0;
      while (busy_a && len < 20) begin
        len++;
        @(negedge slow_clock);
      end
      check("auto_result_len", 32'(len), 32'd4);
      check("auto_idle_lights", {30'd0, pl_a, dl_a}, 32'd0);
    end
    check("auto_other_tallies", {28'd0, dealer_wins_a, ties_a}, 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/baccarat_round_ctrl.md
Name: baccarat_round_ctrl

Overview:
- Parametrised, multi-round successor to the single-hand baccarat controller.
- Sequences the card load strobes for one hand and evaluates naturals, the player third-card rule and the banker third-card rule.
- Holds the result, keeps saturating win/loss/tie tallies, and either waits for an acknowledge or auto-restarts after a hold period.
- Sits between the card datapath (card registers and score logic) and the board LEDs/HEX tally display.

Parameters:
- NATURAL_MIN, 8: two-card score at or above this is a natural (range 8..9).
- PLAYER_DRAW_MAX, 5: player draws a third card when pscore is at or below this.
- BANKER_STAND_MIN, 7: banker never draws at or above this score.
- TALLY_W, 8: width of each saturating tally counter.
- AUTO_NEXT, 0: 1 means RESULT returns to IDLE after HOLD_CYCLES without ack.
- HOLD_CYCLES, 16: result hold time in AUTO_NEXT mode, in slow_clock cycles (≥1).

Ports:
- slow_clock  in  1  system clock.
- resetb  in  1  synchronous reset, active-low.
- start  in  1  begin a hand; sampled only in IDLE.
- ack  in  1  release the result; sampled only in RESULT when AUTO_NEXT=0.
- pscore  in  4  player hand score 0..9, valid the cycle after a load strobe.
- dscore  in  4  dealer hand score 0..9, same timing as pscore.
- pcard3  in  4  player third-card value 0..9, valid the cycle after load_pcard3.
- load_pcard1, load_pcard2, load_pcard3  out  1 each  one-cycle card load strobes.
- load_dcard1, load_dcard2, load_dcard3  out  1 each  one-cycle card load strobes.
- player_win_light  out  1  player won; both win lights high means a tie.
- dealer_win_light  out  1  dealer won.
- busy  out  1  high in every state except IDLE.
- round_done  out  1  single-cycle pulse on entry to RESULT.
- player_wins, dealer_wins, ties  out  TALLY_W each  saturating tallies.

Behaviour:
- Decided interface: one clock; reset is synchronous and active-low. The clock port is slow_clock and the reset port is resetb.
- Reset (resetb low at a posedge, taking effect in any state, including mid-hand):
  - State goes to IDLE.
  - All strobes, lights and round_done are 0.
  - Tallies are cleared to 0 and the hold counter is cleared.
- States: IDLE, P1, D1, P2, D2, EV2, P3, EV3, D3, EVF, RESULT.
- Every state is exactly one cycle except IDLE and RESULT.
- IDLE: when start=1, go to P1.
- P1 -> D1 -> P2 -> D2 -> EV2. Each load state asserts only its own strobe.
- EV2 is the evaluation state; no strobes are asserted. Rules are checked in this order:
  1. Either score ≥ NATURAL_MIN: go to RESULT.
  2. pscore ≤ PLAYER_DRAW_MAX: go to P3.
  3. dscore < BANKER_STAND_MIN - 1: go to D3.
  4. Otherwise go to RESULT.
- P3 -> EV3. In EV3, apply the banker rule (see Optional Feature). Draw goes to D3; stand goes to RESULT.
- D3 -> EVF -> RESULT.
- Winner is computed on entry to RESULT from the then-current scores: pscore>dscore is a player win, equal is a tie, otherwise a dealer win.
- The winner is registered; the lights are driven from that register for the whole of RESULT.
- On the RESULT entry cycle:
  - round_done=1 for one cycle.
  - Exactly one tally increments.
  - A tally at its maximum (all ones) holds; it does not wrap.
- RESULT exit:
  - AUTO_NEXT=0: stay until ack=1, then go to IDLE.
  - AUTO_NEXT=1: the counter loads HOLD_CYCLES-1 on entry and decrements; go to IDLE when it reads 0, and ack is ignored.
- Lights are 0 in every state other than RESULT.
- start is ignored outside IDLE. ack is ignored outside RESULT.
- If start and ack are both high in RESULT, only ack acts; start is re-sampled once in IDLE.
- Score or pcard3 inputs above 9: behaviour is unspecified. The verifier does not drive these values.
- Illegal state encoding: recover to IDLE on the next edge. Do not propagate X.

Optional Feature:
- Macro: BACCARAT_BANKER_TABLE_EN.
- Defined: full punto-banco tableau in EV3, where the banker draws if any of these holds:
  - dscore ≤ 2;
  - dscore=3 and pcard3≠8;
  - dscore=4 and pcard3 in 2..7;
  - dscore=5 and pcard3 in 4..7;
  - dscore=6 and pcard3 in 6..7.
- Undefined: simplified rule in EV3, banker draws iff dscore < BANKER_STAND_MIN - 1; pcard3 is ignored.
- dscore ≥ BANKER_STAND_MIN always stands, in both variants.

Decomposition:
- Package baccarat_pkg holds:
  - the state enum typedef bac_state_t;
  - the result typedef bac_result_t (P_WIN, D_WIN, TIE);
  - the constants NATURAL_MIN_DEF, PLAYER_DRAW_MAX_DEF and BANKER_STAND_MIN_DEF.
- One sub-module, baccarat_tally: three saturating TALLY_W counters with synchronous clear and a one-hot increment input.

Test Plan:
1. Natural: pscore=8, dscore=3 at EV2 -> no P3/D3 strobes; RESULT with player light only; player_wins=1; round_done pulsed once.
2. Player draws, banker tableau (macro defined): pscore=4, dscore=3, pcard3=8 -> P3, then banker stands; final pscore=2, dscore=3 -> dealer light; dealer_wins=1.
3. Same stimulus with the macro undefined -> banker draws (3<6) and D3 strobe seen; final 2 vs 2 -> both lights high; ties=1.
4. AUTO_NEXT=1, HOLD_CYCLES=4 -> RESULT lasts exactly 4 cycles, then IDLE; ack ignored.
5. Saturation: TALLY_W=2, four consecutive player wins -> player_wins reads 1, 2, 3, 3.
6. Reset asserted in P3 -> IDLE next edge; all outputs and tallies 0; a following start yields a P1 strobe one cycle later.
